// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size/state encodings and alignment check for the load/store unit
package lsu_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int TO_W = 4;

    // size 11 is reserved and always rejected as misaligned
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return addr_lo != 2'b00;
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/lsu_lane_fmt.sv
// rtl/lsu_lane_fmt.sv - byte-enable/lane replication for stores, lane extract/extend for loads
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] st_word,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = 8'(ld_word >> {addr_lo, 3'b000});
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        be      = 4'b1111;
        st_word = st_data;
        ld_data = ld_word;
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << addr_lo;
                st_word = {4{st_data[7:0]}};
                ld_data = {{24{sign & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_word = {2{st_data[15:0]}};
                ld_data = {{16{sign & ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_master.sv
// rtl/lsu_master.sv - MEM-stage load/store bus initiator; LSU_TRACE_EN enables store trace output
module lsu_master
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            we_q, we_d, sign_q, sign_d, err_q, err_d;
    logic [1:0]      size_q, size_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d, rdata_q, rdata_d;
    logic [3:0]      be_w;
    logic [31:0]     st_word, ld_data;
    logic            in_req;

    lsu_lane_fmt u_fmt (
        .size    (size_q),
        .sign    (sign_q),
        .addr_lo (addr_q[1:0]),
        .st_data (wdata_q),
        .ld_word (bus_rdata),
        .be      (be_w),
        .st_word (st_word),
        .ld_data (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sign_d  = sign_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                we_d    = req_we;
                sign_d  = req_sign;
                size_d  = req_size;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                pc_d    = req_pc;
                cnt_d   = '0;
                rdata_d = '0;
                if (is_misaligned(req_size, req_addr[1:0])) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    rdata_d = we_q ? '0 : ld_data;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sign_q  <= sign_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // bus side decodes straight from state so async reset drops bus_req at once
    assign in_req    = (state_q == ST_REQ);
    assign bus_req   = in_req;
    assign bus_we    = in_req & we_q;
    assign bus_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus_be    = in_req ? be_w : '0;
    assign bus_wdata = (in_req && we_q) ? st_word : '0;
    assign done      = (state_q == ST_DONE);
    assign stall     = req_valid & ~done;
    assign rdata     = rdata_q;
    assign err       = err_q;

`ifdef LSU_TRACE_EN
    always @(posedge clk) begin
        if (reset && in_req && bus_ack && we_q) begin
            case (size_q)
                SZ_BYTE: $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, wdata_q[7:0]);
                SZ_HALF: $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, wdata_q[15:0]);
                default: $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, wdata_q);
            endcase
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif
endmodule

// File: tb/tb_lsu_master.sv
// tb/tb_lsu_master.sv - directed scoreboard bench for lsu_master
module tb_lsu_master;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_sign = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic        stall, done, err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    int compared = 0;
    int mismatched = 0;

    lsu_master #(.TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc), .stall(stall), .done(done),
        .rdata(rdata), .err(err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // latency c counts cycles after the request was presented; done at c means IDLE + (c-1) more
    task automatic run(input string tag, input logic we, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, input int ack_dly,
                       input logic [31:0] rword, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input int exp_lat, input int exp_reqcyc,
                       input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        exp_t got;
        int   reqcyc = 0;
        bit   fin = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        req_pc    = 32'h0000_1000 + addr;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        sb_q.push_back(e);
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (done) begin
                check({tag, "/latency"}, 32'(c), 32'(exp_lat));
                check({tag, "/req_cycles"}, 32'(reqcyc), 32'(exp_reqcyc));
                check({tag, "/stall_release"}, 32'(stall), 32'd0);
                check({tag, "/sb_depth"}, 32'(sb_q.size()), 32'd1);
                if (sb_q.size() != 0) begin
                    got = sb_q.pop_front();
                    check({tag, "/rdata"}, rdata, got.rdata);
                    check({tag, "/err"}, 32'(err), 32'(got.err));
                end
                fin = 1;
            end else if (bus_req) begin
                if (reqcyc == 0) begin
                    check({tag, "/bus_addr"}, bus_addr, {addr[31:2], 2'b00});
                    check({tag, "/bus_we"}, 32'(bus_we), 32'(we));
                    check({tag, "/stall_held"}, 32'(stall), 32'd1);
                    if (we) begin
                        check({tag, "/bus_be"}, 32'(bus_be), 32'(exp_be));
                        check({tag, "/bus_wdata"}, bus_wdata, exp_wdata);
                    end
                end
                if (reqcyc == ack_dly) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rword;
                end
                reqcyc++;
            end
        end
        req_valid = 1'b0;
        if (!fin) check({tag, "/done_seen"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        check({tag, "/done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset/bus_req", 32'(bus_req), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/err", 32'(err), 32'd0);
        check("reset/rdata", rdata, 32'd0);
        check("reset/bus_be", 32'(bus_be), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run("sw", 1, 2'b00, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 2, 1, 32'h0, 0);
        run("sb", 1, 2'b01, 0, 32'h13, 32'h000000A5, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 2, 1, 32'h0, 0);
        run("sh", 1, 2'b10, 0, 32'h16, 32'h1234BEEF, 2, 32'h0, 4'b1100, 32'hBEEFBEEF, 4, 3, 32'h0, 0);
        run("lb_s", 0, 2'b01, 1, 32'h21, 32'h0, 0, 32'h00008000, 4'b0, 32'h0, 2, 1, 32'hFFFFFF80, 0);
        run("lbu", 0, 2'b01, 0, 32'h21, 32'h0, 0, 32'h00008000, 4'b0, 32'h0, 2, 1, 32'h00000080, 0);
        run("lhu", 0, 2'b10, 0, 32'h22, 32'h0, 0, 32'h80010000, 4'b0, 32'h0, 2, 1, 32'h00008001, 0);
        run("lh_s", 0, 2'b10, 1, 32'h22, 32'h0, 1, 32'h80010000, 4'b0, 32'h0, 3, 2, 32'hFFFF8001, 0);
        run("lw", 0, 2'b00, 0, 32'h24, 32'h0, 1, 32'h12345678, 4'b0, 32'h0, 3, 2, 32'h12345678, 0);
        run("lw_mis", 0, 2'b00, 0, 32'h22, 32'h0, 0, 32'hFFFFFFFF, 4'b0, 32'h0, 1, 0, 32'h0, 1);
        run("sh_mis", 1, 2'b10, 0, 32'h23, 32'h5555, 0, 32'h0, 4'b0, 32'h0, 1, 0, 32'h0, 1);
        run("sz_rsv", 0, 2'b11, 0, 32'h30, 32'h0, 0, 32'hFFFFFFFF, 4'b0, 32'h0, 1, 0, 32'h0, 1);
        run("timeout", 0, 2'b00, 0, 32'h30, 32'h0, 99, 32'h0, 4'b0, 32'h0, 16, 15, 32'h0, 1);

        // reset asserted mid-transaction while the responder is still waiting
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_addr  = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid/bus_req_before", 32'(bus_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid/bus_req_drop", 32'(bus_req), 32'd0);
        check("rst_mid/done", 32'(done), 32'd0);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_mid/no_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        run("lw_after_rst", 0, 2'b00, 0, 32'h44, 32'h0, 0, 32'hCAFEF00D, 4'b0, 32'h0, 2, 1, 32'hCAFEF00D, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
